// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access pipeline stage: operation codes,
// bus widths, FSM state encoding and access-size helpers.
package mem_access_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned OP_W   = 8;
   localparam int unsigned SEL_W  = 4;

   localparam logic [OP_W-1:0] OP_LB  = 8'hE0;
   localparam logic [OP_W-1:0] OP_LH  = 8'hE1;
   localparam logic [OP_W-1:0] OP_LW  = 8'hE3;
   localparam logic [OP_W-1:0] OP_LBU = 8'hE4;
   localparam logic [OP_W-1:0] OP_LHU = 8'hE5;
   localparam logic [OP_W-1:0] OP_SB  = 8'hE8;
   localparam logic [OP_W-1:0] OP_SH  = 8'hE9;
   localparam logic [OP_W-1:0] OP_SW  = 8'hEB;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } acc_size_t;

   function automatic logic is_load(input logic [OP_W-1:0] op);
      return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
             (op == OP_LHU) || (op == OP_LW);
   endfunction

   function automatic logic is_store(input logic [OP_W-1:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   // Non-memory codes report SZ_WORD; callers qualify with is_load/is_store.
   function automatic acc_size_t acc_size(input logic [OP_W-1:0] op);
      acc_size_t sz;
      case (op)
         OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
         default:              sz = SZ_WORD;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half lane of a big-endian read word and
// sign- or zero-extends it according to the load opcode.
module mem_load_align
   import mem_access_pkg::*;
(
   input  logic [OP_W-1:0]   aluop,
   input  logic [1:0]        addr_lsb,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] ld_data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Address 00 maps to the most significant lane.
   always_comb begin
      case (addr_lsb)
         2'b00:   byte_lane = rdata[31:24];
         2'b01:   byte_lane = rdata[23:16];
         2'b10:   byte_lane = rdata[15:8];
         default: byte_lane = rdata[7:0];
      endcase
      half_lane = addr_lsb[1] ? rdata[15:0] : rdata[31:16];
   end

   always_comb begin
      case (aluop)
         OP_LB:   ld_data = {{24{byte_lane[7]}}, byte_lane};
         OP_LBU:  ld_data = {24'h000000, byte_lane};
         OP_LH:   ld_data = {{16{half_lane[15]}}, half_lane};
         OP_LHU:  ld_data = {16'h0000, half_lane};
         default: ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: issues data-memory requests for loads/stores, stalls
// the pipeline until the memory acknowledges, and forwards results to MEM/WB.
//
// state   | meaning
// IDLE    | pass-through; aligned load/store raises request and stall
// BUSY    | request held, waiting for dmem_ack (no timeout)
// DONE    | one cycle presenting the final result, stall released
module mem_access
   import mem_access_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] ex_wd,
   input  logic              ex_wreg,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic [DATA_W-1:0] ex_hi,
   input  logic [DATA_W-1:0] ex_lo,
   input  logic              ex_whilo,
   input  logic [OP_W-1:0]   ex_aluop,
   input  logic [ADDR_W-1:0] ex_mem_addr,
   input  logic [DATA_W-1:0] ex_reg2,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [SEL_W-1:0]  dmem_sel,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [REG_AW-1:0] mem_wd,
   output logic              mem_wreg,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_hi,
   output logic [DATA_W-1:0] mem_lo,
   output logic              mem_whilo,
   output logic              stallreq,
   output logic              mem_misalign
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] ld_word_q;
   logic [DATA_W-1:0] ld_ext;

   logic              op_load, op_store, op_mem, misaligned;
   acc_size_t         size_c;
   logic              req_c, stall_c, misal_c, wreg_c, bus_act;
   logic [DATA_W-1:0] mwdata_c;
   logic [SEL_W-1:0]  sel_c;
   logic [DATA_W-1:0] st_data_c;

   assign op_load    = is_load(ex_aluop);
   assign op_store   = is_store(ex_aluop);
   assign op_mem     = op_load || op_store;
   assign size_c     = acc_size(ex_aluop);
   assign misaligned = ((size_c == SZ_HALF) && ex_mem_addr[0]) ||
                       ((size_c == SZ_WORD) && (ex_mem_addr[1:0] != 2'b00));

   mem_load_align u_align (
      .aluop    (ex_aluop),
      .addr_lsb (ex_mem_addr[1:0]),
      .rdata    (ld_word_q),
      .ld_data  (ld_ext)
   );

   // Reset wins over dmem_ack, so an ack coinciding with rst is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ld_word_q <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == ST_BUSY) && dmem_ack) begin
            ld_word_q <= dmem_rdata;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      req_c    = 1'b0;
      stall_c  = 1'b0;
      misal_c  = 1'b0;
      wreg_c   = ex_wreg;
      mwdata_c = ex_wdata;
      case (state_q)
         ST_IDLE: begin
            if (op_mem) begin
               wreg_c   = 1'b0;
               mwdata_c = '0;
               if (misaligned) begin
                  misal_c = 1'b1;
               end else begin
                  req_c   = 1'b1;
                  stall_c = 1'b1;
                  state_d = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            req_c    = 1'b1;
            stall_c  = 1'b1;
            wreg_c   = 1'b0;
            mwdata_c = '0;
            if (dmem_ack) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d  = ST_IDLE;
            mwdata_c = op_load ? ld_ext : ex_wdata;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      sel_c     = 4'b1111;
      st_data_c = ex_reg2;
      case (size_c)
         SZ_BYTE: begin
            st_data_c = {4{ex_reg2[7:0]}};
            case (ex_mem_addr[1:0])
               2'b00:   sel_c = 4'b1000;
               2'b01:   sel_c = 4'b0100;
               2'b10:   sel_c = 4'b0010;
               default: sel_c = 4'b0001;
            endcase
         end
         SZ_HALF: begin
            st_data_c = {2{ex_reg2[15:0]}};
            sel_c     = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
         end
         default: begin
            sel_c     = 4'b1111;
            st_data_c = ex_reg2;
         end
      endcase
   end

   // Outputs are forced to zero for as long as rst is high.
   assign bus_act      = !rst && req_c;
   assign dmem_req     = bus_act;
   assign dmem_we      = bus_act && op_store;
   assign dmem_addr    = bus_act ? {ex_mem_addr[31:2], 2'b00} : '0;
   assign dmem_sel     = bus_act ? sel_c : '0;
   assign dmem_wdata   = (bus_act && op_store) ? st_data_c : '0;
   assign stallreq     = !rst && stall_c;
   assign mem_misalign = !rst && misal_c;
   assign mem_wreg     = !rst && wreg_c;
   assign mem_wdata    = rst ? '0 : mwdata_c;
   assign mem_wd       = rst ? '0 : ex_wd;
   assign mem_hi       = rst ? '0 : ex_hi;
   assign mem_lo       = rst ? '0 : ex_lo;
   assign mem_whilo    = !rst && ex_whilo;

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: a transaction-level model derives each
// cycle's expected outputs and one compare process checks them every cycle.
module tb_mem_access;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  ex_wd = '0;
   logic        ex_wreg = 1'b0;
   logic [31:0] ex_wdata = '0, ex_hi = '0, ex_lo = '0;
   logic        ex_whilo = 1'b0;
   logic [7:0]  ex_aluop = '0;
   logic [31:0] ex_mem_addr = '0, ex_reg2 = '0, dmem_rdata = '0;
   logic        dmem_ack = 1'b0;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_sel;
   logic [4:0]  mem_wd;
   logic        mem_wreg, mem_whilo, stallreq, mem_misalign;
   logic [31:0] mem_wdata, mem_hi, mem_lo;

   mem_access dut (
      .clk(clk), .rst(rst), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
      .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo), .ex_aluop(ex_aluop),
      .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_sel(dmem_sel), .dmem_wdata(dmem_wdata),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
      .stallreq(stallreq), .mem_misalign(mem_misalign)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] mwdata;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        whilo;
      logic        stall;
      logic        mis;
   } exp_t;

   localparam int PH_RST   = 0;
   localparam int PH_PASS  = 1;
   localparam int PH_MISAL = 2;
   localparam int PH_STALL = 3;
   localparam int PH_FINAL = 4;

   exp_t exp_v = '0;
   bit   chk   = 1'b0;
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
      end
   endtask

   function automatic bit tb_is_load(input logic [7:0] op);
      return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
   endfunction

   function automatic bit tb_is_store(input logic [7:0] op);
      return op inside {OP_SB, OP_SH, OP_SW};
   endfunction

   function automatic int tb_bytes(input logic [7:0] op);
      if (op inside {OP_LB, OP_LBU, OP_SB}) return 1;
      if (op inside {OP_LH, OP_LHU, OP_SH}) return 2;
      return 4;
   endfunction

   function automatic bit tb_misaligned(input logic [7:0] op, input logic [31:0] a);
      return (a % tb_bytes(op)) != 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] a,
                                              input logic [31:0] w);
      int          nb;
      int          sh;
      logic [31:0] mask, v;
      nb = tb_bytes(op);
      if (nb == 4) return w;
      sh   = 8 * (4 - nb - int'(a[1:0]));
      mask = (nb == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
      v    = (w >> sh) & mask;
      if ((op == OP_LB || op == OP_LH) && v[8*nb-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic exp_t build_exp(input int ph, input logic [31:0] rword);
      exp_t e;
      int   nb;
      e = '0;
      if (ph == PH_RST) return e;
      e.wd = ex_wd; e.hi = ex_hi; e.lo = ex_lo; e.whilo = ex_whilo;
      e.wreg = ex_wreg; e.mwdata = ex_wdata;
      nb = tb_bytes(ex_aluop);
      case (ph)
         PH_MISAL: begin e.wreg = 1'b0; e.mwdata = '0; e.mis = 1'b1; end
         PH_STALL: begin
            e.wreg = 1'b0; e.mwdata = '0; e.req = 1'b1; e.stall = 1'b1;
            e.we   = tb_is_store(ex_aluop);
            e.addr = ex_mem_addr & 32'hFFFF_FFFC;
            if (nb == 1) e.sel = 4'b1000 >> ex_mem_addr[1:0];
            else if (nb == 2) e.sel = 4'b1100 >> (2 * int'(ex_mem_addr[1]));
            else e.sel = 4'b1111;
            if (e.we) begin
               if (nb == 1) e.wdata = (ex_reg2 & 32'hFF) * 32'h0101_0101;
               else if (nb == 2) e.wdata = (ex_reg2 & 32'hFFFF) * 32'h0001_0001;
               else e.wdata = ex_reg2;
            end
         end
         PH_FINAL: if (tb_is_load(ex_aluop)) e.mwdata = model_load(ex_aluop, ex_mem_addr, rword);
         default: ;
      endcase
      return e;
   endfunction

   always @(negedge clk) begin
      if (chk) begin
         check("dmem_req", dmem_req, exp_v.req);
         check("dmem_we", dmem_we, exp_v.we);
         check("dmem_addr", dmem_addr, exp_v.addr);
         check("dmem_sel", dmem_sel, exp_v.sel);
         check("dmem_wdata", dmem_wdata, exp_v.wdata);
         check("mem_wd", mem_wd, exp_v.wd);
         check("mem_wreg", mem_wreg, exp_v.wreg);
         check("mem_wdata", mem_wdata, exp_v.mwdata);
         check("mem_hi", mem_hi, exp_v.hi);
         check("mem_lo", mem_lo, exp_v.lo);
         check("mem_whilo", mem_whilo, exp_v.whilo);
         check("stallreq", stallreq, exp_v.stall);
         check("mem_misalign", mem_misalign, exp_v.mis);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_ex(input logic [7:0] op);
      ex_aluop = op;
      ex_wd    = 5'($urandom_range(0, 31));
      ex_wreg  = tb_is_load(op) ? 1'b1 : 1'($urandom_range(0, 1));
      ex_wdata = $urandom(); ex_hi = $urandom(); ex_lo = $urandom();
      ex_whilo = 1'($urandom_range(0, 1));
      ex_mem_addr = $urandom(); ex_reg2 = $urandom();
   endtask

   task automatic non_mem_op();
      logic [7:0] op;
      do op = 8'($urandom_range(0, 255)); while (tb_is_load(op) || tb_is_store(op));
      randomize_ex(op);
      dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom();
      exp_v = build_exp(PH_PASS, '0);
      step();
   endtask

   task automatic mem_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [31:0] rword, input int extra, input logic first_ack,
                         input bit use_lit, input logic [31:0] lit_data, input logic [3:0] lit_sel);
      randomize_ex(op);
      ex_mem_addr = addr; ex_reg2 = reg2;
      dmem_ack = first_ack; dmem_rdata = $urandom();
      if (tb_misaligned(op, addr)) begin
         exp_v = build_exp(PH_MISAL, '0);
         if (use_lit) begin
            @(negedge clk);
            check("lit_misalign", mem_misalign, 32'd1);
            check("lit_misalign_req", dmem_req, 32'd0);
            check("lit_misalign_stall", stallreq, 32'd0);
            check("lit_misalign_wreg", mem_wreg, 32'd0);
         end
         step();
         return;
      end
      exp_v = build_exp(PH_STALL, '0);
      if (use_lit && tb_is_store(op)) begin
         @(negedge clk);
         check("lit_store_sel", dmem_sel, lit_sel);
         check("lit_store_wdata", dmem_wdata, lit_data);
         check("lit_store_we", dmem_we, 32'd1);
      end
      step();
      for (int i = 0; i < extra; i++) begin
         dmem_ack = 1'b0; dmem_rdata = $urandom();
         step();
      end
      dmem_ack = 1'b1; dmem_rdata = rword;
      step();
      dmem_ack = 1'b0; dmem_rdata = $urandom();
      exp_v = build_exp(PH_FINAL, rword);
      if (use_lit && tb_is_load(op)) begin
         @(negedge clk);
         check("lit_load_wdata", mem_wdata, lit_data);
         check("lit_load_wreg", mem_wreg, 32'd1);
         check("lit_load_stall", stallreq, 32'd0);
      end
      step();
   endtask

   task automatic reset_cycles(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         randomize_ex(8'($urandom_range(0, 255)));
         dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom();
         exp_v = build_exp(PH_RST, '0);
         step();
      end
      rst = 1'b0;
   endtask

   localparam logic [7:0] MEM_OPS [8] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};

   initial begin
      chk = 1'b1;
      reset_cycles(3);

      mem_op(OP_LW,  32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'h0);
      mem_op(OP_LB,  32'h0000_0103, 32'h0, 32'h0000_00F0, 1, 1'b1, 1'b1, 32'hFFFF_FFF0, 4'h0);
      mem_op(OP_LBU, 32'h0000_0103, 32'h0, 32'h0000_00F0, 0, 1'b0, 1'b1, 32'h0000_00F0, 4'h0);
      mem_op(OP_LH,  32'h0000_0200, 32'h0, 32'h8001_1234, 2, 1'b0, 1'b1, 32'hFFFF_8001, 4'h0);
      mem_op(OP_SH,  32'h0000_0102, 32'h1234_ABCD, 32'h0, 0, 1'b0, 1'b1, 32'hABCD_ABCD, 4'b0011);
      mem_op(OP_SB,  32'h0000_0101, 32'h0000_0057, 32'h0, 1, 1'b0, 1'b1, 32'h5757_5757, 4'b0100);
      mem_op(OP_LW,  32'h0000_0101, 32'h0, 32'h0, 0, 1'b0, 1'b1, 32'h0, 4'h0);
      non_mem_op();

      // Reset arriving in BUSY after three wait cycles, with an ack on the reset cycle.
      randomize_ex(OP_LW);
      ex_mem_addr = 32'h0000_0400; dmem_ack = 1'b0;
      exp_v = build_exp(PH_STALL, '0);
      step();
      for (int i = 0; i < 3; i++) step();
      rst = 1'b1; dmem_ack = 1'b1;
      exp_v = build_exp(PH_RST, '0);
      step();
      rst = 1'b0;
      mem_op(OP_LW, 32'h0000_0404, 32'h0, 32'h0BAD_CAFE, 0, 1'b1, 1'b1, 32'h0BAD_CAFE, 4'h0);

      for (int n = 0; n < 250; n++) begin
         if ($urandom_range(0, 9) < 3) begin
            non_mem_op();
         end else begin
            mem_op(MEM_OPS[$urandom_range(0, 7)], $urandom(), $urandom(), $urandom(),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, '0, '0);
         end
         if ($urandom_range(0, 49) == 0) reset_cycles(1);
      end

      chk = 1'b0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
